// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: FSM state encoding and port index type.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int NUM_PORTS = 2;

  typedef logic port_idx_t;

  // Ownership state that corresponds to granting a given port.
  function automatic arb_state_t own_state(input port_idx_t p);
    return p ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_select.sv
// Round-robin grant selection with bounded hold time. Purely combinational:
// the caller owns the state, last-granted and hold-count flops.
module rr_select
  import dmem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       i_req0,
  input  logic       i_req1,
  input  arb_state_t i_state,
  input  port_idx_t  i_last,
  input  logic [3:0] i_hold_cnt,
  output port_idx_t  o_gnt_idx,
  output logic       o_gnt_valid,
  output arb_state_t o_state_next
);

  port_idx_t w_owner;
  logic      w_own_req;
  logic      w_oth_req;

  assign w_owner   = (i_state == OWN1);
  assign w_own_req = w_owner ? i_req1 : i_req0;
  assign w_oth_req = w_owner ? i_req0 : i_req1;

  // Pick the grant for this cycle and the state that follows from it.
  always_comb begin
    o_gnt_idx   = 1'b0;
    o_gnt_valid = 1'b0;
    unique case (i_state)
      OWN0, OWN1: begin
        if (w_own_req) begin
          o_gnt_valid = 1'b1;
          // The owner gives way only once it has used up its hold budget
          // and the other side is actually waiting.
          if (w_oth_req && (i_hold_cnt >= 4'(MAX_HOLD)))
            o_gnt_idx = ~w_owner;
          else
            o_gnt_idx = w_owner;
        end else if (w_oth_req) begin
          o_gnt_valid = 1'b1;
          o_gnt_idx   = ~w_owner;
        end
      end
      default: begin
        // IDLE: contention goes to whoever was not granted most recently.
        if (i_req0 && i_req1) begin
          o_gnt_valid = 1'b1;
          o_gnt_idx   = ~i_last;
        end else if (i_req0) begin
          o_gnt_valid = 1'b1;
          o_gnt_idx   = 1'b0;
        end else if (i_req1) begin
          o_gnt_valid = 1'b1;
          o_gnt_idx   = 1'b1;
        end
      end
    endcase
    o_state_next = o_gnt_valid ? own_state(o_gnt_idx) : IDLE;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port 0 is the core,
// port 1 the loader/DMA. Grants are combinational, read data returns one
// cycle after the grant. Optional per-port grant and conflict counters are
// built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1,
  output logic [31:0]   conflict_cnt
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  port_idx_t  r_last;
  logic [3:0] r_hold_cnt;
  logic [3:0] w_hold_next;
  port_idx_t  w_gnt_idx;
  logic       w_gnt_valid;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       r_rvalid0;
  logic       r_rvalid1;
  logic [DW-1:0] r_rdata;

  rr_select #(.MAX_HOLD(MAX_HOLD)) u_rr_select (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_state      (r_state),
    .i_last       (r_last),
    .i_hold_cnt   (r_hold_cnt),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_valid  (w_gnt_valid),
    .o_state_next (w_state_next)
  );

  // Grants are suppressed during reset so nothing reaches memory that cycle.
  assign w_gnt0 = w_gnt_valid & ~w_gnt_idx & ~reset;
  assign w_gnt1 = w_gnt_valid &  w_gnt_idx & ~reset;

  // Hold counter: restart on a new owner, saturate while the owner keeps it.
  always_comb begin
    w_hold_next = 4'd0;
    if (w_gnt_valid) begin
      if ((r_state == IDLE) || (w_state_next != r_state))
        w_hold_next = 4'd1;
      else if (r_hold_cnt < 4'(MAX_HOLD))
        w_hold_next = r_hold_cnt + 4'd1;
      else
        w_hold_next = r_hold_cnt;
    end
  end

  // State register with ownership, last-granted port and hold count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_hold_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      if (w_gnt_valid)
        r_last <= w_gnt_idx;
    end
  end

  // Output mux: route the granted port onto the memory interface.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (w_gnt0) begin
      mem_a  = addr0;
      mem_wd = wdata0;
      mem_we = we0;
    end else if (w_gnt1) begin
      mem_a  = addr1;
      mem_wd = wdata1;
      mem_we = we1;
    end
  end

  // Read return: capture memory data one cycle after a granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if ((w_gnt0 & ~we0) | (w_gnt1 & ~we1))
        r_rdata <= mem_rd;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_gnt_cnt0;
  logic [31:0] r_gnt_cnt1;
  logic [31:0] r_conflict_cnt;

  // Free-running wrap-around counters of grants and contention cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_cnt0     <= '0;
      r_gnt_cnt1     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt0)
        r_gnt_cnt0 <= r_gnt_cnt0 + 32'd1;
      if (w_gnt1)
        r_gnt_cnt1 <= r_gnt_cnt1 + 32'd1;
      if (req0 && req1)
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign gnt_cnt0     = r_gnt_cnt0;
  assign gnt_cnt1     = r_gnt_cnt1;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants and write enables are checked each
// cycle; expected read returns go into a queue that a monitor drains on rvalid.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic started = 1'b0;
  logic init_mem = 1'b1;
  logic [32:0] exp_q [$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_HOLD(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
`ifdef DMEM_ARB_PERF_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural dmem: combinational read, write committed on the clock edge.
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (started && (rvalid0 || rvalid1)) begin
      if (rvalid0 && rvalid1) begin
        chk("rvalid_both", {30'd0, rvalid1, rvalid0}, 32'd1);
      end else if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rvalid_port", {31'd0, rvalid1}, {31'd0, e[32]});
        chk("rdata", rdata, e[31:0]);
        $display("read return port %0d data %h", rvalid1, rdata);
      end
    end
  end

  // One bus cycle: drive inputs, check grants mid-cycle, queue expected reads.
  task automatic cyc(input logic rst,
                     input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic eg0, input logic eg1, input logic [31:0] ed);
    reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
    chk("mem_we", {31'd0, mem_we}, {31'd0, (eg0 & w0) | (eg1 & w1)});
    if (eg0 && !w0) exp_q.push_back({1'b0, ed});
    if (eg1 && !w1) exp_q.push_back({1'b1, ed});
    $display("cycle rst=%0b req=%0b%0b gnt=%0b%0b mem_we=%0b mem_a=%h", rst, r1, r0, gnt1, gnt0, mem_we, mem_a);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(posedge clk); #1;
    init_mem = 1'b0;
    started = 1'b1;

    // Writes during reset are dropped.
    cyc(1, 1, 1, 32'h40, 32'h5555_5555, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    cyc(1, 1, 1, 32'h40, 32'h5555_5555, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);

    // First contention after reset goes to port 0; then port 1 alone.
    cyc(0, 1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, 1, 0, 32'hA000_0008);
    cyc(0, 0, 0, 32'h0,  32'h0, 1, 0, 32'h24, 32'h0, 0, 1, 32'hA000_0009);
    idle();

    // Write then read-back; reset-cycle write must not have landed.
    cyc(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hA000_0010);
    idle();

    // Sustained contention: four grants each, alternating.
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      logic g0;
      g0 = (i < 4) || (i >= 8);
`ifdef DMEM_ARB_PERF_EN
      if (i == 10) begin
        chk("gnt_cnt0", gnt_cnt0, 32'd6);
        chk("gnt_cnt1", gnt_cnt1, 32'd4);
        chk("conflict_cnt", conflict_cnt, 32'd10);
      end
`endif
      cyc(0, 1, 0, 32'h00, 32'h0, 1, 0, 32'h04, 32'h0, g0, !g0,
          g0 ? 32'hA000_0000 : 32'hA000_0001);
    end
    idle();

    // Port 1 alone for 20 cycles never loses the grant.
    for (int i = 0; i < 20; i++)
      cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h08, 32'h0, 0, 1, 32'hA000_0002);
    // Saturated hold count: port 0 takes over immediately, then keeps it.
    cyc(0, 1, 0, 32'h0C, 32'h0, 1, 0, 32'h08, 32'h0, 1, 0, 32'hA000_0003);
    cyc(0, 1, 0, 32'h0C, 32'h0, 1, 0, 32'h08, 32'h0, 1, 0, 32'hA000_0003);
    idle();

    // Reset in the middle of a port-1 write burst.
    cyc(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'h1111_1111, 0, 1, 32'h0);
    cyc(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h34, 32'h2222_2222, 0, 0, 32'h0);
    chk("midrst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("midrst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h34, 32'h0, 0, 1, 32'hA000_000D);
    cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, 0, 1, 32'h1111_1111);
    idle();
    idle();

    if (exp_q.size() != 0)
      chk("pending_reads", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
